// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 register file and exception-commit unit at the MEM stage.
// Commits precise exceptions/interrupts and ERET, serves MFC0/MTC0, and
// produces the flush/redirect pair that steers instruction fetch.
module cp0_exc_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_CP0WrEn,
  input  logic [7:0]  MEM_CP0Addr,
  input  logic [31:0] MEM_GPR_RT,
  input  logic        MEM_Exception,
  input  logic [4:0]  MEM_ExcCode,
  input  logic        MEM_isBD,
  input  logic [31:0] MEM_PC,
  input  logic [31:0] badvaddr,
  input  logic        MEM_eret_flush,
  input  logic [5:0]  ext_int,
  output logic [31:0] CP0Out,
  output logic        exc_flush,
  output logic [31:0] exc_npc,
  output logic        Status_EXL
);

  localparam logic [7:0]  ADDR_BADVADDR = 8'h40;
  localparam logic [7:0]  ADDR_COUNT    = 8'h48;
  localparam logic [7:0]  ADDR_COMPARE  = 8'h58;
  localparam logic [7:0]  ADDR_STATUS   = 8'h60;
  localparam logic [7:0]  ADDR_CAUSE    = 8'h68;
  localparam logic [7:0]  ADDR_EPC      = 8'h70;
  localparam logic [31:0] EXC_VECTOR    = 32'hbfc0_0380;

  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q,    count_d;
  logic [31:0] compare_q,  compare_d;
  logic [31:0] epc_q,      epc_d;
  logic        tick_q,     tick_d;
  logic [7:0]  im_q,       im_d;
  logic        exl_q,      exl_d;
  logic        ie_q,       ie_d;
  logic        bd_q,       bd_d;
  logic        ti_q,       ti_d;
  logic [5:0]  ip_hw_q,    ip_hw_d;
  logic [1:0]  ip_sw_q,    ip_sw_d;
  logic [4:0]  exccode_q,  exccode_d;

  logic        int_take;
  logic        exc_take;
  logic        eret_take;
  logic [4:0]  exc_code;
  logic [31:0] status_rd;
  logic [31:0] cause_rd;

  assign status_rd = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_rd  = {bd_q, ti_q, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b0};

  // Event arbitration: interrupt beats synchronous exception beats ERET; a bubble never takes an interrupt.
  always_comb begin
    int_take  = (MEM_PC != 32'd0) && ie_q && !exl_q && (|({ip_hw_q, ip_sw_q} & im_q));
    exc_take  = int_take | MEM_Exception;
    exc_code  = int_take ? 5'd0 : MEM_ExcCode;
    eret_take = MEM_eret_flush && !exc_take;
    exc_flush = exc_take | eret_take;
    exc_npc   = exc_take ? EXC_VECTOR : epc_q;
    Status_EXL = exl_q;
  end

  // MFC0 read mux; unmapped addresses read as zero.
  always_comb begin
    CP0Out = 32'd0;
    case (MEM_CP0Addr)
      ADDR_BADVADDR: CP0Out = badvaddr_q;
      ADDR_COUNT:    CP0Out = count_q;
      ADDR_COMPARE:  CP0Out = compare_q;
      ADDR_STATUS:   CP0Out = status_rd;
      ADDR_CAUSE:    CP0Out = cause_rd;
      ADDR_EPC:      CP0Out = epc_q;
      default:       CP0Out = 32'd0;
    endcase
  end

  // Next-state: free-running timer and IP sampling, then exception commit, ERET, or MTC0 (mutually exclusive).
  always_comb begin
    badvaddr_d = badvaddr_q;
    compare_d  = compare_q;
    epc_d      = epc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    tick_d     = ~tick_q;
    count_d    = count_q + {31'b0, tick_q};
    ip_hw_d    = {ext_int[5] | ti_q, ext_int[4:0]};
    ti_d       = ti_q;
    if ((count_q == compare_q) && (compare_q != 32'd0)) ti_d = 1'b1;

    if (exc_take) begin
      if (!exl_q) begin
        epc_d = MEM_isBD ? (MEM_PC - 32'd4) : MEM_PC;
        bd_d  = MEM_isBD;
      end
      exl_d     = 1'b1;
      exccode_d = exc_code;
      if ((exc_code == 5'd4) || (exc_code == 5'd5)) badvaddr_d = badvaddr;
    end else if (eret_take) begin
      exl_d = 1'b0;
    end else if (MEM_CP0WrEn) begin
      case (MEM_CP0Addr)
        ADDR_COUNT: begin
          count_d = MEM_GPR_RT;
          tick_d  = 1'b0;
        end
        ADDR_COMPARE: begin
          compare_d = MEM_GPR_RT;
          ti_d      = 1'b0;
        end
        ADDR_STATUS: begin
          im_d  = MEM_GPR_RT[15:8];
          exl_d = MEM_GPR_RT[1];
          ie_d  = MEM_GPR_RT[0];
        end
        ADDR_CAUSE: ip_sw_d = MEM_GPR_RT[9:8];
        ADDR_EPC:   epc_d   = MEM_GPR_RT;
        default: ;
      endcase
    end
  end

  // State registers; reset clears everything immediately, BEV is hardwired in the read path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      epc_q      <= 32'd0;
      tick_q     <= 1'b0;
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_hw_q    <= 6'd0;
      ip_sw_q    <= 2'd0;
      exccode_q  <= 5'd0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      tick_q     <= tick_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Self-checking bench for cp0_exc_unit: directed scenarios plus randomized
// traffic, every cycle compared against a word-level reference model.
module tb_cp0_exc_unit;

  localparam logic [31:0] VEC = 32'hbfc0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_CP0WrEn;
  logic [7:0]  MEM_CP0Addr;
  logic [31:0] MEM_GPR_RT;
  logic        MEM_Exception;
  logic [4:0]  MEM_ExcCode;
  logic        MEM_isBD;
  logic [31:0] MEM_PC;
  logic [31:0] badvaddr;
  logic        MEM_eret_flush;
  logic [5:0]  ext_int;
  logic [31:0] CP0Out;
  logic        exc_flush;
  logic [31:0] exc_npc;
  logic        Status_EXL;

  cp0_exc_unit dut (
    .clk(clk), .rst(rst), .MEM_CP0WrEn(MEM_CP0WrEn), .MEM_CP0Addr(MEM_CP0Addr),
    .MEM_GPR_RT(MEM_GPR_RT), .MEM_Exception(MEM_Exception), .MEM_ExcCode(MEM_ExcCode),
    .MEM_isBD(MEM_isBD), .MEM_PC(MEM_PC), .badvaddr(badvaddr),
    .MEM_eret_flush(MEM_eret_flush), .ext_int(ext_int), .CP0Out(CP0Out),
    .exc_flush(exc_flush), .exc_npc(exc_npc), .Status_EXL(Status_EXL)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: whole architectural register words.
  logic [31:0] m_bva, m_count, m_compare, m_status, m_cause, m_epc;
  logic        m_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bva = 0; m_count = 0; m_compare = 0; m_status = 32'h0040_0000;
    m_cause = 0; m_epc = 0; m_tick = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h40: return m_bva;
      8'h48: return m_count;
      8'h58: return m_compare;
      8'h60: return m_status;
      8'h68: return m_cause;
      8'h70: return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic idle();
    MEM_CP0WrEn = 0; MEM_CP0Addr = 0; MEM_GPR_RT = 0; MEM_Exception = 0;
    MEM_ExcCode = 0; MEM_isBD = 0; MEM_PC = 0; badvaddr = 0;
    MEM_eret_flush = 0; ext_int = 0;
  endtask

  // Check current outputs against the model, advance the model, then one clock.
  task automatic cycle();
    logic exl, ie, pend, itake, exc, eret, hit;
    logic [4:0] code;
    logic [31:0] n_bva, n_count, n_compare, n_status, n_cause, n_epc;
    logic n_tick;
    #1;
    exl   = m_status[1];
    ie    = m_status[0];
    pend  = |(m_cause[15:8] & m_status[15:8]);
    itake = (MEM_PC != 0) && ie && !exl && pend;
    exc   = itake || MEM_Exception;
    code  = itake ? 5'd0 : MEM_ExcCode;
    eret  = MEM_eret_flush && !exc;
    chk("CP0Out", CP0Out, m_read(MEM_CP0Addr));
    chk("exc_flush", 32'(exc_flush), 32'(exc || eret));
    if (exc || eret) chk("exc_npc", exc_npc, exc ? VEC : m_epc);
    chk("Status_EXL", 32'(Status_EXL), 32'(exl));

    n_bva = m_bva; n_compare = m_compare; n_status = m_status; n_epc = m_epc;
    n_cause = m_cause;
    n_cause[15:10] = {ext_int[5] | m_cause[30], ext_int[4:0]};
    hit = (m_count == m_compare) && (m_compare != 0);
    if (hit) n_cause[30] = 1'b1;
    n_count = m_tick ? m_count + 1 : m_count;
    n_tick  = !m_tick;
    if (exc) begin
      if (!exl) begin
        n_epc = MEM_isBD ? MEM_PC - 4 : MEM_PC;
        n_cause[31] = MEM_isBD;
      end
      n_status[1] = 1'b1;
      n_cause[6:2] = code;
      if (code == 5'd4 || code == 5'd5) n_bva = badvaddr;
    end else if (eret) begin
      n_status[1] = 1'b0;
    end else if (MEM_CP0WrEn) begin
      case (MEM_CP0Addr)
        8'h48: begin n_count = MEM_GPR_RT; n_tick = 0; end
        8'h58: begin n_compare = MEM_GPR_RT; n_cause[30] = 1'b0; end
        8'h60: n_status = (m_status & ~32'h0000_ff03) | (MEM_GPR_RT & 32'h0000_ff03);
        8'h68: n_cause = (n_cause & ~32'h0000_0300) | (MEM_GPR_RT & 32'h0000_0300);
        8'h70: n_epc = MEM_GPR_RT;
        default: ;
      endcase
    end
    m_bva = n_bva; m_count = n_count; m_compare = n_compare; m_status = n_status;
    m_cause = n_cause; m_epc = n_epc; m_tick = n_tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    idle();
    MEM_CP0WrEn = 1; MEM_CP0Addr = a; MEM_GPR_RT = d;
    cycle();
  endtask

  // Asynchronous reset pulse starting between edges, held across one rising edge.
  task automatic reset_pulse();
    idle();
    #1 rst = 0;
    MEM_CP0Addr = 8'h60;
    #1 chk("rst_status", CP0Out, 32'h0040_0000);
    MEM_CP0Addr = 8'h68;
    #1 chk("rst_cause", CP0Out, 32'h0);
    MEM_CP0Addr = 8'h70;
    #1 chk("rst_epc", CP0Out, 32'h0);
    chk("rst_flush", 32'(exc_flush), 32'h0);
    chk("rst_exl", 32'(Status_EXL), 32'h0);
    @(negedge clk);
    rst = 1;
    model_reset();
  endtask

  logic [7:0] addr_pool [8] = '{8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h40, 8'h41, 8'hff};
  logic       ti_seen;

  initial begin
    idle();
    rst = 0;
    model_reset();
    @(negedge clk);
    rst = 1;
    cycle();
    cycle();

    // Overflow in a delay slot.
    idle();
    MEM_Exception = 1; MEM_ExcCode = 5'd12; MEM_isBD = 1; MEM_PC = 32'hbfc0_0104;
    #1 chk("ov_flush", 32'(exc_flush), 32'h1);
    chk("ov_npc", exc_npc, VEC);
    cycle();
    idle();
    MEM_CP0Addr = 8'h70;
    #1 chk("ov_epc", CP0Out, 32'hbfc0_0100);
    MEM_CP0Addr = 8'h68;
    #1 chk("ov_cause", CP0Out, 32'h8000_0030);
    chk("ov_exl", 32'(Status_EXL), 32'h1);
    cycle();

    // AdEL then ERET.
    idle();
    MEM_Exception = 1; MEM_ExcCode = 5'd4; MEM_PC = 32'h8000_0010; badvaddr = 32'h8000_0003;
    cycle();
    idle();
    MEM_CP0Addr = 8'h40;
    #1 chk("adel_bva", CP0Out, 32'h8000_0003);
    cycle();
    idle();
    MEM_eret_flush = 1;
    #1 chk("eret_flush", 32'(exc_flush), 32'h1);
    chk("eret_npc", exc_npc, 32'hbfc0_0100);
    cycle();
    idle();
    #1 chk("eret_exl", 32'(Status_EXL), 32'h0);
    cycle();

    // Nested exception keeps the first EPC.
    idle();
    MEM_Exception = 1; MEM_ExcCode = 5'd10; MEM_PC = 32'h8000_1000;
    cycle();
    idle();
    MEM_Exception = 1; MEM_ExcCode = 5'd8; MEM_PC = 32'h8000_2000; MEM_isBD = 1;
    cycle();
    idle();
    MEM_CP0Addr = 8'h70;
    #1 chk("nest_epc", CP0Out, 32'h8000_1000);
    MEM_CP0Addr = 8'h68;
    #1 chk("nest_cause", CP0Out & 32'h8000_007c, 32'h0000_0020);
    cycle();

    // Timer interrupt.
    mtc0(8'h58, 32'd10);
    mtc0(8'h48, 32'd0);
    mtc0(8'h60, 32'h0040_8001);
    ti_seen = 0;
    for (int i = 0; i < 60 && !ti_seen; i++) begin
      idle();
      MEM_CP0Addr = 8'h68;
      cycle();
      ti_seen = m_cause[30];
    end
    chk("timer_reached", 32'(ti_seen), 32'h1);
    idle();
    MEM_CP0Addr = 8'h68;
    #1 chk("timer_ti", 32'(CP0Out[30]), 32'h1);
    cycle();
    idle();
    MEM_CP0Addr = 8'h68;
    #1 chk("timer_ip7", 32'(CP0Out[15]), 32'h1);
    MEM_PC = 32'h8000_3000;
    #1 chk("int_flush", 32'(exc_flush), 32'h1);
    chk("int_npc", exc_npc, VEC);
    cycle();
    idle();
    MEM_CP0Addr = 8'h68;
    #1 chk("int_code", 32'(CP0Out[6:2]), 32'h0);
    MEM_CP0Addr = 8'h70;
    #1 chk("int_epc", CP0Out, 32'h8000_3000);
    cycle();
    mtc0(8'h58, 32'd100);
    idle();
    MEM_CP0Addr = 8'h68;
    #1 chk("ti_clear", 32'(CP0Out[30]), 32'h0);
    cycle();

    // MTC0 to Status collides with an exception.
    idle();
    MEM_CP0WrEn = 1; MEM_CP0Addr = 8'h60; MEM_GPR_RT = 32'hffff_ffff;
    MEM_Exception = 1; MEM_ExcCode = 5'd12; MEM_PC = 32'h8000_4000;
    cycle();
    idle();
    MEM_CP0Addr = 8'h60;
    #1 chk("coll_status", CP0Out, 32'h0040_8003);
    cycle();

    reset_pulse();
    cycle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) reset_pulse();
      idle();
      MEM_CP0Addr = addr_pool[$urandom_range(0, 7)];
      MEM_CP0WrEn = ($urandom_range(0, 2) == 0) && (MEM_CP0Addr != 8'h40);
      case (MEM_CP0Addr)
        8'h48:   MEM_GPR_RT = $urandom_range(0, 30);
        8'h58:   MEM_GPR_RT = $urandom_range(0, 40);
        default: MEM_GPR_RT = $urandom;
      endcase
      MEM_Exception  = ($urandom_range(0, 9) == 0);
      MEM_ExcCode    = 5'($urandom);
      MEM_isBD       = 1'($urandom);
      MEM_PC         = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom & 32'hffff_fffc);
      badvaddr       = $urandom;
      MEM_eret_flush = ($urandom_range(0, 7) == 0);
      ext_int        = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cp0_exc_unit.md
# cp0_exc_unit

Coprocessor-0 register file and exception-commit unit at the MEM stage of the MIPS pipeline. It is the consumer end of the exception information carried down the pipeline registers: excode, BD flag, PC, bad address and ERET. It commits precise exceptions and interrupts into BadVAddr/Count/Compare/Status/Cause/EPC, and returns the flush and redirect PC that drive the fetch stage. It also serves MFC0 reads and MTC0 writes.

## Interface
- No parameters. Exception vector fixed at 32'hbfc0_0380.
- clk  in  1  core clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- MEM_CP0WrEn  in  1  MTC0 write enable
- MEM_CP0Addr  in  8  register select {rd[4:0], sel[2:0]}
- MEM_GPR_RT  in  32  MTC0 write data
- MEM_Exception  in  1  synchronous exception flagged on the MEM instruction
- MEM_ExcCode  in  5  excode of that exception
- MEM_isBD  in  1  MEM instruction is in a delay slot
- MEM_PC  in  32  MEM instruction PC; 0 marks a bubble
- badvaddr  in  32  faulting address from the pipeline register
- MEM_eret_flush  in  1  ERET in MEM
- ext_int  in  6  hardware interrupt lines, level-sensitive
- CP0Out  out  32  combinational read data for MEM_CP0Addr
- exc_flush  out  1  flush IF/ID/EX/MEM this cycle
- exc_npc  out  32  redirect PC, valid while exc_flush=1
- Status_EXL  out  1  current Status.EXL

## Operation
- Addresses: BadVAddr 8'h40, Count 8'h48, Compare 8'h58, Status 8'h60, Cause 8'h68, EPC 8'h70. Any other address reads 0 and ignores writes.
- Reset values:
  - Status = 32'h0040_0000 (BEV=1, read-only).
  - All other registers = 0.
  - Internal tick = 0.
  - Outputs follow: exc_flush=0, Status_EXL=0.
- Status writable bits: IM[15:8], EXL[1], IE[0]. All other bits are read-only.
- Cause layout:
  - BD[31] and TI[30] are read-only.
  - IP[15:10] = {ext_int[5] | TI, ext_int[4:0]}, registered every cycle.
  - IP[9:8] are software-writable.
  - ExcCode[6:2] is read-only.
- Count:
  - The tick flop toggles every cycle; Count increments when tick=1, i.e. every 2nd cycle, and wraps 32'hffff_ffff -> 0.
  - An MTC0 to Count loads the value and clears tick.
- Timer: TI is set when Count == Compare and Compare != 0, evaluated on registered values. TI is cleared by any MTC0 to Compare; that write has priority over a same-cycle set.
- int_take = MEM_PC != 0 && IE && !EXL && |(Cause.IP & Status.IM). An interrupt takes priority over MEM_Exception, with excode 0.
- Exception commit, when int_take | MEM_Exception:
  - If EXL=0: EPC <= MEM_isBD ? MEM_PC-4 : MEM_PC, and Cause.BD <= MEM_isBD.
  - If EXL=1: EPC and BD are unchanged.
  - Always: EXL <= 1 and Cause.ExcCode <= code.
  - BadVAddr <= badvaddr only when code is 4 (AdEL) or 5 (AdES).
  - exc_flush=1, exc_npc=32'hbfc0_0380.
- ERET, with no exception in the same cycle: EXL <= 0, exc_flush=1, exc_npc=EPC (the registered value).
- Priority: exception/interrupt > ERET > MTC0. A suppressed MTC0 writes nothing.

## Timing
- CP0Out, exc_flush and exc_npc are combinational from current-cycle inputs and registered state.
- Register updates land on the next rising edge.
- No write-to-read bypass: an MFC0 in the cycle after an MTC0 sees the new value; in the same cycle it sees the old value.
- exc_flush is high for exactly one cycle per event. The pipeline bubble (MEM_PC=0) that follows cannot retrigger an interrupt.
- Reset deassertion mid-count: Count restarts from 0 with tick=0. Reset assertion clears every register immediately, without a clock edge.

## Test plan
- Reset: pulse rst low between clock edges -> Status=32'h0040_0000, Cause=0, EPC=0, and exc_flush=0 immediately.
- Overflow in delay slot: MEM_Exception=1, ExcCode=12, isBD=1, PC=32'hbfc0_0104 -> exc_flush=1, exc_npc=32'hbfc0_0380; next cycle EPC=32'hbfc0_0100, Cause=32'h8000_0030, EXL=1.
- AdEL: ExcCode=4, badvaddr=32'h8000_0003 -> BadVAddr=32'h8000_0003. Follow with ERET -> exc_npc=EPC, EXL=0.
- Nested exception with EXL=1 -> EPC keeps its first value; ExcCode is updated.
- Timer: write Compare=10, Count=0, Status=32'h0040_8001 -> at Count=10 TI=1 and Cause.IP7=1. With a valid MEM_PC, an interrupt is taken with ExcCode 0. A write to Compare clears TI.
- Simultaneous MTC0 to Status and MEM_Exception -> Status receives only EXL=1; the MTC0 data is discarded.
